control_unit: RTL and testbench

Multicycle MIPS main controller: a Moore finite-state machine that sequences each instruction through fetch, decode, execute, memory and writeback steps. It decodes the 6-bit opcode and drives every datapath enable and mux select of the multicycle processor core: PC, instruction register, register file, memory and ALU. It contains no datapath storage of its own.

---
 rtl/mips_pkg.sv | 41 ++++
 rtl/control_unit.sv | 137 +++++++++++++
 tb/tb_control_unit.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcodes, FSM state encoding and datapath select encodings for the multicycle MIPS core
package mips_pkg;

   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_LHU   = 6'b100111;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXEC   = 4'd6,
      ALUWB  = 4'd7,
      BRANCH = 4'd8,
      JUMP   = 4'd9,
      ADDIEX = 4'd10,
      ADDIWB = 4'd11
   } state_t;

   localparam logic [1:0] SRCB_RT     = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMMSH2 = 2'b10;
   localparam logic [1:0] SRCB_IMM    = 2'b11;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;
   localparam logic [1:0] PCSRC_RS     = 2'b11;

endpackage

// File: rtl/control_unit.sv
// rtl/control_unit.sv - Moore FSM main controller for the multicycle MIPS core
// Optional ADDI support via CONTROL_UNIT_ADDI_EN.
module control_unit
   import mips_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       is_lw,
   output logic       MemRead,
   output logic       IorD,
   output logic       ALUSrcA,
   output logic       PCWrite,
   output logic       IRWrite,
   output logic       MemWrite,
   output logic       RegDst,
   output logic       RegWrite,
   output logic       MemtoReg,
   output logic       PCWriteCond,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] PCSource
);

   state_t state, state_next;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= FETCH;
      else       state <= state_next;
   end

   always_comb begin
      state_next = FETCH;
      case (state)
         FETCH:  state_next = DECODE;
         DECODE: begin
            case (opcode)
               OP_LW, OP_LHU, OP_SW: state_next = MEMADR;
               OP_RTYPE:             state_next = EXEC;
               OP_BEQ:               state_next = BRANCH;
               OP_J:                 state_next = JUMP;
`ifdef CONTROL_UNIT_ADDI_EN
               OP_ADDI:              state_next = ADDIEX;
`endif
               default:              state_next = FETCH;
            endcase
         end
         MEMADR: state_next = is_lw ? MEMRD : MEMWR;
         MEMRD:  state_next = MEMWB;
         EXEC:   state_next = ALUWB;
`ifdef CONTROL_UNIT_ADDI_EN
         ADDIEX: state_next = ADDIWB;
`endif
         default: state_next = FETCH;
      endcase
   end

   // Address/ALU selects are held into the access state because the ALU result is not registered.
   always_comb begin
      MemRead     = 1'b0;
      IorD        = 1'b0;
      ALUSrcA     = 1'b0;
      PCWrite     = 1'b0;
      IRWrite     = 1'b0;
      MemWrite    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      MemtoReg    = 1'b0;
      PCWriteCond = 1'b0;
      ALUSrcB     = SRCB_RT;
      ALUOp       = ALUOP_ADD;
      PCSource    = PCSRC_ALU;
      case (state)
         FETCH: begin
            MemRead = 1'b1;
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            ALUSrcB = SRCB_FOUR;
         end
         DECODE: ALUSrcB = SRCB_IMMSH2;
         MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
         end
         MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
         end
         MEMWB: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
         end
         MEMWR: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
            ALUSrcA  = 1'b1;
            ALUSrcB  = SRCB_IMM;
         end
         EXEC: begin
            ALUSrcA = 1'b1;
            ALUOp   = ALUOP_RTYPE;
         end
         ALUWB: begin
            RegWrite = 1'b1;
            RegDst   = 1'b1;
            ALUSrcA  = 1'b1;
            ALUOp    = ALUOP_RTYPE;
         end
         BRANCH: begin
            ALUSrcA     = 1'b1;
            ALUOp       = ALUOP_SUB;
            PCWriteCond = 1'b1;
            PCSource    = PCSRC_ALUOUT;
         end
         JUMP: begin
            PCWrite  = 1'b1;
            PCSource = PCSRC_JUMP;
         end
`ifdef CONTROL_UNIT_ADDI_EN
         ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
         end
         ADDIWB: begin
            RegWrite = 1'b1;
            ALUSrcA  = 1'b1;
            ALUSrcB  = SRCB_IMM;
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - table-driven self-checking bench for control_unit (ADDI cases follow CONTROL_UNIT_ADDI_EN)
module tb_control_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode;
   logic       zero;
   logic       is_lw;
   logic       MemRead, IorD, ALUSrcA, PCWrite, IRWrite, MemWrite;
   logic       RegDst, RegWrite, MemtoReg, PCWriteCond;
   logic [1:0] ALUSrcB, ALUOp, PCSource;

   control_unit dut (
      .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .is_lw(is_lw),
      .MemRead(MemRead), .IorD(IorD), .ALUSrcA(ALUSrcA), .PCWrite(PCWrite),
      .IRWrite(IRWrite), .MemWrite(MemWrite), .RegDst(RegDst), .RegWrite(RegWrite),
      .MemtoReg(MemtoReg), .PCWriteCond(PCWriteCond), .ALUSrcB(ALUSrcB),
      .ALUOp(ALUOp), .PCSource(PCSource)
   );

   always #5 clk = ~clk;

   // {MemRead,IorD,ALUSrcA,PCWrite,IRWrite,MemWrite,RegDst,RegWrite,MemtoReg,PCWriteCond,ALUSrcB,ALUOp,PCSource}
   wire [15:0] outs = {MemRead, IorD, ALUSrcA, PCWrite, IRWrite, MemWrite, RegDst, RegWrite,
                       MemtoReg, PCWriteCond, ALUSrcB, ALUOp, PCSource};

   localparam logic [15:0] E_FETCH  = 16'h9810;
   localparam logic [15:0] E_DECODE = 16'h0020;
   localparam logic [15:0] E_MEMADR = 16'h2030;
   localparam logic [15:0] E_MEMRD  = 16'hE030;
   localparam logic [15:0] E_MEMWB  = 16'h0180;
   localparam logic [15:0] E_MEMWR  = 16'h6430;
   localparam logic [15:0] E_EXEC   = 16'h2008;
   localparam logic [15:0] E_ALUWB  = 16'h2308;
   localparam logic [15:0] E_BRANCH = 16'h2045;
   localparam logic [15:0] E_JUMP   = 16'h1002;
   localparam logic [15:0] E_ADDIEX = 16'h2030;
   localparam logic [15:0] E_ADDIWB = 16'h2130;

   typedef struct {
      string          name;
      logic [5:0]     op;
      logic           lw;
      int             len;
      logic [4:0][15:0] exp;
   } vec_t;

   vec_t vecs[9];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   function automatic vec_t mk(input string n, input logic [5:0] op, input logic lw, input int len,
                               input logic [15:0] e0, e1, e2, e3, e4);
      vec_t v;
      v.name = n; v.op = op; v.lw = lw; v.len = len;
      v.exp = {e4, e3, e2, e1, e0};
      return v;
   endfunction

   // Correct inputs only in their sampling state; corrupted values elsewhere must have no effect.
   task automatic run_vec(input vec_t v);
      for (int c = 0; c < v.len; c++) begin
         opcode = (c == 1) ? v.op : ~v.op;
         is_lw  = (c == 2) ? v.lw : ~v.lw;
         zero   = c[0];
         #1;
         check($sformatf("%s cycle %0d", v.name, c + 1), outs, v.exp[c]);
         @(negedge clk);
      end
   endtask

   initial begin
      vecs[0] = mk("lw",    6'b100011, 1'b1, 5, E_FETCH, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB);
      vecs[1] = mk("lhu",   6'b100111, 1'b1, 5, E_FETCH, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB);
      vecs[2] = mk("sw",    6'b101011, 1'b0, 4, E_FETCH, E_DECODE, E_MEMADR, E_MEMWR, 16'h0);
      vecs[3] = mk("lw_islw0", 6'b100011, 1'b0, 4, E_FETCH, E_DECODE, E_MEMADR, E_MEMWR, 16'h0);
      vecs[4] = mk("rtype", 6'b000000, 1'b0, 4, E_FETCH, E_DECODE, E_EXEC, E_ALUWB, 16'h0);
      vecs[5] = mk("beq",   6'b000100, 1'b0, 3, E_FETCH, E_DECODE, E_BRANCH, 16'h0, 16'h0);
      vecs[6] = mk("j",     6'b000010, 1'b0, 3, E_FETCH, E_DECODE, E_JUMP, 16'h0, 16'h0);
      vecs[7] = mk("nop",   6'b111111, 1'b0, 2, E_FETCH, E_DECODE, 16'h0, 16'h0, 16'h0);
`ifdef CONTROL_UNIT_ADDI_EN
      vecs[8] = mk("addi",  6'b001000, 1'b0, 4, E_FETCH, E_DECODE, E_ADDIEX, E_ADDIWB, 16'h0);
`else
      vecs[8] = mk("addi",  6'b001000, 1'b0, 2, E_FETCH, E_DECODE, 16'h0, 16'h0, 16'h0);
`endif

      opcode = 6'b000000;
      is_lw  = 1'b0;
      zero   = 1'b0;
      reset  = 1'b1;
      #2;
      check("reset async", outs, E_FETCH);
      repeat (2) @(negedge clk);
      check("reset held", outs, E_FETCH);
      reset = 1'b0;

      for (int i = 0; i < 9; i++) run_vec(vecs[i]);
      #1;
      check("back to fetch", outs, E_FETCH);

      // Reset pulsed during MEMRD: outputs must return to FETCH before any clock edge.
      opcode = 6'b100011;
      is_lw  = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("pre-reset memrd", outs, E_MEMRD);
      #1;
      reset = 1'b1;
      #1;
      check("reset mid memrd", outs, E_FETCH);
      @(negedge clk);
      check("reset through edge", outs, E_FETCH);
      reset = 1'b0;
      run_vec(vecs[5]);
      #1;
      check("after restart", outs, E_FETCH);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: simulation did not complete, expected finish before 20000");
      $fatal(1);
   end

endmodule
